// File: rtl/modn_pkg.sv
// Shared types and constants for the modulo-N run controller and its counter datapath.
package modn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MOD_MIN = 2;

endpackage : modn_pkg

// File: rtl/modn_counter.sv
// Programmable modulo-N counter datapath: synchronous clear, count enable, wrap at N-1.
module modn_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign at_max = (q_q == n - WIDTH'(1));
  assign q      = q_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (en) begin
      q_d = at_max ? '0 : q_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule : modn_counter

// File: rtl/modn_seq_ctrl.sv
// Run controller: sequences a modulo-N counter through a budget of full wraps, with pause/abort and done/err pulses.
module modn_seq_ctrl
  import modn_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [CYC_W-1:0] cycles,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             cnt_clear;
  logic             cnt_en;
  logic             at_max;
  logic             wrap_evt;

  modn_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .en     (cnt_en),
    .n      (n_q),
    .q      (q),
    .at_max (at_max)
  );

  assign cnt_en   = (state_q == RUN) && !pause;
  assign wrap_evt = cnt_en && at_max;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cyc_d     = cyc_q;
    wrap_d    = wrap_q;
    err_d     = 1'b0;
    cnt_clear = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      wrap_d    = '0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (mod_val >= WIDTH'(MOD_MIN)) begin
              n_d       = mod_val;
              cyc_d     = cycles;
              wrap_d    = '0;
              cnt_clear = 1'b1;
              state_d   = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (wrap_evt) begin
            // Saturate so an endless run (cycles==0) never aliases back onto a budget.
            wrap_d = (wrap_q == '1) ? wrap_q : wrap_q + CYC_W'(1);
            if ((cyc_q != '0) && (wrap_q + CYC_W'(1) == cyc_q)) begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      cyc_q   <= '0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cyc_q   <= cyc_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign tc   = (state_q == RUN) && !pause && at_max;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule : modn_seq_ctrl

// File: tb/tb_modn_seq_ctrl.sv
// Directed scoreboard bench for modn_seq_ctrl: expected frames are queued per cycle and checked at the falling edge.
module tb_modn_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int CYC_W = 4;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             start   = 1'b0;
  logic [WIDTH-1:0] mod_val = '0;
  logic [CYC_W-1:0] cycles  = '0;
  logic             pause   = 1'b0;
  logic             abort   = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc, busy, done, err;

  always #5 clk = ~clk;

  modn_seq_ctrl #(
    .WIDTH (WIDTH),
    .CYC_W (CYC_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mod_val (mod_val),
    .cycles  (cycles),
    .pause   (pause),
    .abort   (abort),
    .q       (q),
    .tc      (tc),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct packed {
    logic             err;
    logic             done;
    logic             busy;
    logic             tc;
    logic [WIDTH-1:0] q;
  } frame_t;

  frame_t exp_q[$];
  string  tag_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic expect_f(input string tag, input int eq, input logic etc,
                          input logic ebusy, input logic edone, input logic eerr);
    frame_t f;
    f.err  = eerr;
    f.done = edone;
    f.busy = ebusy;
    f.tc   = etc;
    f.q    = WIDTH'(eq);
    exp_q.push_back(f);
    tag_q.push_back(tag);
  endtask

  task automatic idle_frame(input string tag);
    expect_f(tag, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Unpaused run frames: q walks 0..n-1 repeatedly, tc only on n-1.
  task automatic push_run(input string tag, input int n, input int len);
    for (int i = 0; i < len; i++) begin
      expect_f(tag, i % n, (i % n) == n - 1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then check one queued frame at the falling edge.
  task automatic cyc(input logic r, input logic s, input int m, input int c,
                     input logic p, input logic a);
    frame_t obs, e;
    string  tag;
    @(posedge clk);
    #1;
    reset   = r;
    start   = s;
    mod_val = WIDTH'(m);
    cycles  = CYC_W'(c);
    pause   = p;
    abort   = a;
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed q=%0d with no expected frame queued", q);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = '{err: err, done: done, busy: busy, tc: tc, q: q};
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s: observed q=%0d tc=%b busy=%b done=%b err=%b, expected q=%0d tc=%b busy=%b done=%b err=%b",
               tag, obs.q, obs.tc, obs.busy, obs.done, obs.err, e.q, e.tc, e.busy, e.done, e.err);
      end
    end
  endtask

  initial begin
    // Reset held three cycles, then released.
    repeat (4) idle_frame("reset");
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // N=5, two wraps; start during DONE must be ignored.
    idle_frame("t2_accept");
    cyc(0, 1, 5, 2, 0, 0);
    push_run("t2_run", 5, 10);
    repeat (10) cyc(0, 0, 5, 2, 0, 0);
    expect_f("t2_done", 0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1, 5, 1, 0, 0);
    idle_frame("t2_busy_fall");
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t2_done_start_ignored");
    cyc(0, 0, 0, 0, 0, 0);

    // N=3, one wrap, four paused cycles at q=1.
    idle_frame("t3_accept");
    cyc(0, 1, 3, 1, 0, 0);
    expect_f("t3_q0", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (4) expect_f("t3_paused", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    expect_f("t3_resume", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_f("t3_q2", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_f("t3_done", 0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t3_idle");
    cyc(0, 0, 0, 0, 0, 0);

    // Rejected starts: mod_val 1 then 0.
    idle_frame("t4_req1");
    cyc(0, 1, 1, 3, 0, 0);
    expect_f("t4_err1", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t4_clear1");
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t4_req0");
    cyc(0, 1, 0, 3, 0, 0);
    expect_f("t4_err0", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t4_clear0");
    cyc(0, 0, 0, 0, 0, 0);

    // N=7 endless run, abort after 20 cycles.
    idle_frame("t5_accept");
    cyc(0, 1, 7, 0, 0, 0);
    push_run("t5_run", 7, 20);
    repeat (20) cyc(0, 0, 0, 0, 0, 0);
    expect_f("t5_abort_cycle", 6, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    idle_frame("t5_after_abort");
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t5_no_done");
    cyc(0, 0, 0, 0, 0, 0);

    // N=4, one wrap: ignored mid-run start, abort on the final wrap cycle.
    idle_frame("t6a_accept");
    cyc(0, 1, 4, 1, 0, 0);
    expect_f("t6a_q0", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_f("t6a_q1", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1, 6, 3, 0, 0);
    expect_f("t6a_q2", 2, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_f("t6a_q3_n_kept", 3, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    idle_frame("t6a_aborted");
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t6a_no_done");
    cyc(0, 0, 0, 0, 0, 0);

    // Same run, reset on the final wrap cycle.
    idle_frame("t6b_accept");
    cyc(0, 1, 4, 1, 0, 0);
    push_run("t6b_run", 4, 3);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    expect_f("t6b_q3", 3, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_frame("t6b_reset");
    cyc(0, 0, 0, 0, 0, 0);
    idle_frame("t6b_no_done");
    cyc(0, 0, 0, 0, 0, 0);

    // N=2 endless run past 15 wraps (saturation), pause at N-1 masks tc, then abort.
    idle_frame("t7_accept");
    cyc(0, 1, 2, 0, 0, 0);
    push_run("t7_run", 2, 40);
    repeat (40) cyc(0, 0, 0, 0, 0, 0);
    expect_f("t7_q0", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_f("t7_pause_tc", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 1, 0);
    expect_f("t7_unpause_tc", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_f("t7_abort_cycle", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 0, 1);
    idle_frame("t7_idle");
    cyc(0, 0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_bad++;
      $error("FAIL scoreboard_leftover: observed %0d unchecked frames, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_modn_seq_ctrl

// File: doc/modn_seq_ctrl.md
# modn_seq_ctrl

Run controller for a programmable modulo-N counter. It accepts a start request with a modulus and a wrap budget, then sequences the counter through the requested number of full 0..N-1 passes. It supports pause and abort, and reports completion with a one-cycle done pulse. It generalises the fixed MOD-5 counter into a scheduled, handshaked resource that other blocks in the design can drive.

## Interface
Parameters:
- WIDTH, 3, counter width; legal modulus range is 2..2^WIDTH-1.
- CYC_W, 4, width of the wrap budget and wrap counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- start  in  1  run request; sampled only in IDLE.
- mod_val  in  WIDTH  modulus N; latched on an accepted start.
- cycles  in  CYC_W  number of full wraps to run; 0 means run until abort. Latched on an accepted start.
- pause  in  1  level input; holds the count while in RUN.
- abort  in  1  level input; returns to IDLE from any state without done.
- q  out  WIDTH  current count value.
- tc  out  1  terminal count; combinational, = RUN & !pause & q==N-1.
- busy  out  1  = state != IDLE.
- done  out  1  high for exactly one cycle, in the DONE state.
- err  out  1  registered one-cycle pulse; start was rejected because mod_val < 2.

## Operation
- States: IDLE, RUN, DONE.
- Priority on each edge: reset > abort > start/run logic > pause > count.
- Reset: state=IDLE, q=0, wrap count=0, latched N=0, latched cycles=0, done=0, err=0, tc=0, busy=0.
- IDLE with start=1 and mod_val>=2:
  - latch N and cycles;
  - set q=0 and wrap count=0;
  - go to RUN.
- IDLE with start=1 and mod_val<2: err=1 for the next cycle; stay in IDLE; q stays 0.
- start outside IDLE is ignored. The latched N and cycles never change mid-run.
- RUN with pause=0:
  - if q==N-1: q<=0 and wrap count++;
  - otherwise q<=q+1.
- RUN with pause=1: q and wrap count hold; tc=0.
- RUN completion: on the wrap edge where the incremented wrap count equals cycles (cycles≠0), go to DONE with q=0.
- cycles=0: stay in RUN indefinitely. The wrap count saturates at 2^CYC_W-1 and must not roll over.
- DONE: done=1 for one cycle, then unconditionally IDLE. start during DONE is ignored.
- abort=1 in any state: next state IDLE, q=0, wrap count=0, no done pulse. abort wins over a simultaneous wrap completion.
- pause in IDLE or DONE has no effect.

## Timing
- Start-accept latency is one edge: q=0 and busy=1 on the cycle after start is sampled.
- q advances once per unpaused RUN cycle.
- A run of N and C wraps, with no pause, lasts N·C RUN cycles plus 1 DONE cycle.
- busy falls on the cycle after done.
- The earliest next accepted start is sampled in the first IDLE cycle after DONE.
- tc leads the wrap edge by one cycle, so consumers can register it.
- err and done are registered outputs. q, busy and state come directly from flops.

## Structure
- Shared package modn_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the minimum-modulus constant MOD_MIN=2.
- Sub-module modn_counter is the datapath: clear, enable, N → q, tc, with a synchronous clear.
- The FSM, wrap counter, latches and error pulse live in modn_seq_ctrl.

## Test plan
- Reset held 3 cycles, then released → q=0, busy=0, done=0, err=0, state=IDLE.
- start with mod_val=5, cycles=2 → q sequence 0,1,2,3,4,0,1,2,3,4 over 10 RUN cycles; tc high when q=4; done high one cycle with q=0; busy low on the following cycle.
- mod_val=3, cycles=1, pause=1 for 4 cycles while q=1 → q holds at 1 during the pause, tc=0; done arrives exactly 4 cycles later than in the unpaused run.
- start with mod_val=1, and again with mod_val=0 → err pulses one cycle each; busy stays 0.
- mod_val=7, cycles=0, abort asserted after 20 cycles → q cycles 0..6 continuously; on abort, q=0 and IDLE next cycle; done never asserts.
- mod_val=4, cycles=1, abort and reset each asserted on the final wrap cycle → no done pulse, and state=IDLE. Also assert start during RUN with mod_val=6 → it is ignored, and N stays 4.
